perf_report: RTL
================

PERF_REPORT -- requirements
Module: perf_report

Interface
REQ-001 SHALL have parameter HDR_BYTE, default 8'hA5: header byte sent first when PERF_RPT_HDR_EN is defined.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port stp_cnt, input, 1: the same stop pulse that freezes the performance counters; it requests a report.
REQ-005 SHALL have port instr_cnt, input, 16: retired-instruction count from the performance counter.
REQ-006 SHALL have port cycle_cnt, input, 16: cycle count from the performance counter.
REQ-007 SHALL have port tx_data, output, 8: report byte presented to the IO pipe.
REQ-008 SHALL have port tx_valid, output, 1: tx_data holds a valid byte.
REQ-009 SHALL have port tx_ready, input, 1: the IO pipe accepts the byte this cycle.
REQ-010 SHALL have port busy, output, 1: a report is in progress.
REQ-011 SHALL have port done, output, 1: one-cycle pulse after the last byte transfers.
REQ-012 SHALL have port drop, output, 1: sticky flag; a stp_cnt arrived while busy.

Function
REQ-013 SHALL implement FSM states IDLE, SETTLE, SEND.
REQ-014 IDLE: when stp_cnt=1, SHALL go to SETTLE and assert busy on the next cycle.
REQ-015 SETTLE: SHALL last exactly one cycle, then capture instr_cnt and cycle_cnt into internal snapshot registers, load the byte index to 0 and go to SEND.
REQ-016 SHALL send bytes in this order: cycle_cnt[15:8], cycle_cnt[7:0], instr_cnt[15:8], instr_cnt[7:0], all taken from the snapshot.
REQ-017 SEND: SHALL keep tx_valid=1 and tx_data stable until tx_valid&&tx_ready; on that transfer SHALL advance to the next byte in the same cycle (no bubble).
REQ-018 On transfer of the last byte: SHALL return to IDLE on the next cycle, deassert tx_valid and busy, and pulse done for exactly one cycle.
REQ-019 SHALL ignore changes on instr_cnt and cycle_cnt after capture.
REQ-020 stp_cnt while state is not IDLE (including the last-byte transfer cycle): SHALL set drop and start no new report.
REQ-021 stp_cnt in the cycle done=1: the FSM is already IDLE, so SHALL accept it as a new request.
REQ-022 tx_ready held low indefinitely: SHALL hold the state; no timeout.
REQ-023 tx_valid SHALL be 0 in IDLE and SETTLE.
REQ-024 Byte index SHALL be 3 bits wide with no wrap; SEND SHALL end at the last index.

Reset
REQ-025 rst=1 SHALL force state IDLE, tx_valid=0, tx_data=8'h00, busy=0, done=0, drop=0, snapshot=0, index=0.
REQ-026 rst asserted mid-report SHALL abort the report immediately; no remaining bytes SHALL be emitted.
REQ-027 rst SHALL take priority over stp_cnt in the same cycle.

Configuration
REQ-028 PERF_RPT_HDR_EN defined: SHALL send HDR_BYTE before the four payload bytes (5 bytes total); done SHALL follow the 5th transfer.
REQ-029 PERF_RPT_HDR_EN undefined: SHALL send 4 bytes only; the HDR_BYTE parameter SHALL be present but unused.

Structure
REQ-030 Package perf_rpt_pkg SHALL hold the state enum (IDLE, SETTLE, SEND), the payload byte count constant (4), the header default constant (8'hA5) and the byte-index width.
REQ-031 Sub-module perf_rpt_txreg SHALL implement the tx_data/tx_valid holding register and the valid/ready transfer detect; the FSM and snapshot SHALL stay in perf_report.

Verification
REQ-032 Scenario 1: no header, tx_ready=1, cycle_cnt=16'h1234, instr_cnt=16'h0ABC, one stp_cnt pulse -> SETTLE 1 cycle, then bytes 12,34,0A,BC on 4 consecutive cycles, done 1 cycle later, busy low after.
REQ-033 Scenario 2: scenario 1 with tx_ready toggling 0,1,0,0,1... -> tx_data is stable whenever valid&&!ready; the same 4 bytes arrive in order.
REQ-034 Scenario 3: counts change to 16'hFFFF after the SETTLE capture -> output is still 12,34,0A,BC.
REQ-035 Scenario 4: second stp_cnt during SEND -> drop=1 and stays 1; exactly 4 bytes sent; stp_cnt in the done cycle -> new report starts.
REQ-036 Scenario 5: rst pulsed after the 2nd byte -> all outputs at reset values next cycle; no further bytes.
REQ-037 Scenario 6: PERF_RPT_HDR_EN defined -> bytes A5,12,34,0A,BC; done after the 5th.

Source files
------------

// File: rtl/perf_rpt_pkg.sv
// Shared types and constants for the performance-counter report block.
// The header byte option is enabled by defining PERF_RPT_HDR_EN.
package perf_rpt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SEND   = 2'd2
    } state_e;

    localparam int          PAYLOAD_BYTES = 4;
    localparam logic [7:0]  HDR_DEFAULT   = 8'hA5;
    localparam int          IDX_W         = 3;

    // Position 0 is the header; positions 1..4 are the counter bytes, MSB first.
    function automatic logic [7:0] rpt_byte(
        input logic [7:0]       hdr,
        input logic [15:0]      cyc,
        input logic [15:0]      ins,
        input logic [IDX_W-1:0] pos
    );
        logic [7:0] b;
        b = 8'h00;
        case (pos)
            3'd0:    b = hdr;
            3'd1:    b = cyc[15:8];
            3'd2:    b = cyc[7:0];
            3'd3:    b = ins[15:8];
            3'd4:    b = ins[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/perf_rpt_txreg.sv
// Output holding register for the report byte stream plus the valid/ready
// transfer detect; the byte stays put until the IO pipe takes it.
module perf_rpt_txreg
    import perf_rpt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       clear,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       xfer
);

    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;

    // NOTE: every signal written here gets a default first, so no latch can form.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = load_data;
            valid_d = 1'b1;
        end else if (clear) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign tx_data  = data_q;
    assign tx_valid = valid_q;
    assign xfer     = valid_q & tx_ready;

endmodule

// File: rtl/perf_report.sv
// Serialises a frozen snapshot of the cycle/instruction counters onto a
// valid/ready byte pipe. Define PERF_RPT_HDR_EN to prefix the HDR_BYTE header.
module perf_report
    import perf_rpt_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE = HDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stp_cnt,
    input  logic [15:0] instr_cnt,
    input  logic [15:0] cycle_cnt,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        drop
);

`ifdef PERF_RPT_HDR_EN
    localparam int              NBYTES  = PAYLOAD_BYTES + 1;
    localparam logic [IDX_W-1:0] POS_OFS = 3'd0;
`else
    localparam int              NBYTES  = PAYLOAD_BYTES;
    localparam logic [IDX_W-1:0] POS_OFS = 3'd1;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [15:0]      snap_cyc_q, snap_cyc_d;
    logic [15:0]      snap_ins_q, snap_ins_d;
    logic             done_q, done_d;
    logic             drop_q, drop_d;

    logic             tx_load;
    logic             tx_clear;
    logic [7:0]       tx_byte;
    logic             xfer;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_cyc_d = snap_cyc_q;
        snap_ins_d = snap_ins_q;
        done_d     = 1'b0;
        drop_d     = drop_q | (stp_cnt && (state_q != IDLE));
        tx_load    = 1'b0;
        tx_clear   = 1'b0;
        tx_byte    = 8'h00;

        case (state_q)
            IDLE: begin
                if (stp_cnt) state_d = SETTLE;
            end
            SETTLE: begin
                // The first byte comes straight from the values being captured.
                snap_cyc_d = cycle_cnt;
                snap_ins_d = instr_cnt;
                idx_d      = '0;
                tx_load    = 1'b1;
                tx_byte    = rpt_byte(HDR_BYTE, cycle_cnt, instr_cnt, POS_OFS);
                state_d    = SEND;
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        tx_clear = 1'b1;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        tx_load = 1'b1;
                        tx_byte = rpt_byte(HDR_BYTE, snap_cyc_q, snap_ins_q,
                                           idx_q + 3'd1 + POS_OFS);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the snapshot is an ordinary register, so it is cleared on reset like the rest.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            snap_cyc_q <= 16'h0000;
            snap_ins_q <= 16'h0000;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            snap_cyc_q <= snap_cyc_d;
            snap_ins_q <= snap_ins_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    perf_rpt_txreg u_txreg (
        .clk       (clk),
        .rst       (rst),
        .load      (tx_load),
        .load_data (tx_byte),
        .clear     (tx_clear),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .xfer      (xfer)
    );

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign drop = drop_q;

endmodule
